axi_read_responder: RTL and testbench

AXI_READ_RESPONDER -- requirements
Module: axi_read_responder

---
 rtl/axi_read_responder.sv | 198 +++++++++++++++++++
 tb/tb_axi_read_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// AXI4 read-only slave serving bursts from a backdoor-preloaded store of 64-bit words.
// Define AXI_RESP_STALL_EN to insert a one-cycle rvalid bubble between beats of a burst.
module axi_read_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic        s_axi_rlast,
    output logic [1:0]  s_axi_rresp,
    input  logic        mem_we,
    input  logic [63:0] mem_waddr,
    input  logic [63:0] mem_wdata
);
    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned LW  = 4;
    localparam logic [LW-1:0] LAT = LW'(RD_LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_e;
    typedef enum logic [1:0] {M_FIXED, M_INCR, M_WRAP} mode_e;

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d, cap_mode;
    logic          arready_q, arready_d;
    logic          rvalid_q, rvalid_d;
    logic          rlast_q, rlast_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [63:0]   addr_q, addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_q, beat_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          slverr_q, slverr_d, cap_slverr;
    logic          wrap_len_ok;
    logic [7:0]    beat_nxt;
    logic [63:0]   incr_addr, wrap_mask, next_addr;

    logic [63:0]   mem_q [MEM_WORDS];
    logic          unused_waddr_bits;

    function automatic logic out_of_range(input logic [63:0] a);
        return |a[63:AW+3];
    endfunction

    function automatic logic [1:0] resp_of(input logic [63:0] a, input logic slv);
        if (out_of_range(a)) return 2'b11;
        if (slv)             return 2'b10;
        return 2'b00;
    endfunction

    // Backing store: backdoor writes only, never reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr[AW+2:3]] <= mem_wdata;
    end
    assign unused_waddr_bits = ^{mem_waddr[63:AW+3], mem_waddr[2:0]};

    // Decode of the incoming AR burst type; bad WRAP lengths and reserved types fall back to INCR.
    assign wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                         (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    always_comb begin
        cap_mode   = M_INCR;
        cap_slverr = (s_axi_arsize != 3'd3);
        case (s_axi_arburst)
            2'b00:   cap_mode = M_FIXED;
            2'b01:   cap_mode = M_INCR;
            2'b10: begin
                if (wrap_len_ok) cap_mode = M_WRAP;
                else             cap_slverr = 1'b1;
            end
            default: cap_slverr = 1'b1;
        endcase
    end

    // Address of the following beat.
    assign beat_nxt  = beat_q + 8'd1;
    assign incr_addr = addr_q + 64'd8;
    assign wrap_mask = 64'({len_q, 3'b111});
    always_comb begin
        next_addr = incr_addr;
        case (mode_q)
            M_FIXED: next_addr = addr_q;
            M_WRAP:  next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: next_addr = incr_addr;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        slverr_d  = slverr_q;
        unique case (state_q)
            IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    addr_d    = s_axi_araddr;
                    len_d     = s_axi_arlen;
                    mode_d    = cap_mode;
                    slverr_d  = cap_slverr;
                    beat_d    = 8'd0;
                    lat_d     = LAT;
                    arready_d = 1'b0;
                    if (LAT == '0) begin
                        state_d  = BURST;
                        rvalid_d = 1'b1;
                        rlast_d  = (s_axi_arlen == 8'd0);
                        rresp_d  = resp_of(s_axi_araddr, cap_slverr);
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                lat_d = lat_q - LW'(1);
                if (lat_q == LW'(1)) begin
                    state_d  = BURST;
                    rvalid_d = 1'b1;
                    rlast_d  = (len_q == 8'd0);
                    rresp_d  = resp_of(addr_q, slverr_q);
                end
            end
            BURST: begin
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        state_d   = IDLE;
                        arready_d = 1'b1;
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        rresp_d   = 2'b00;
                        beat_d    = 8'd0;
                    end else begin
                        beat_d  = beat_nxt;
                        addr_d  = next_addr;
                        rlast_d = (beat_nxt == len_q);
                        rresp_d = resp_of(next_addr, slverr_q);
`ifdef AXI_RESP_STALL_EN
                        rvalid_d = 1'b0;
`else
                        rvalid_d = 1'b1;
`endif
                    end
                end else if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mode_q    <= M_INCR;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= 2'b00;
            addr_q    <= 64'd0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            lat_q     <= '0;
            slverr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            slverr_q  <= slverr_d;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = (rvalid_q && !out_of_range(addr_q)) ? mem_q[addr_q[AW+2:3]] : 64'd0;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: table of bursts checked through a beat scoreboard,
// plus hand sequences for rready back-pressure and reset mid-burst.
module tb_axi_read_responder;
    localparam int unsigned MEM_WORDS  = 1024;
    localparam int unsigned RD_LATENCY = 2;
    localparam logic [63:0] MEM_BYTES  = 64'(MEM_WORDS) * 64'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [63:0] s_axi_araddr = '0;
    logic [7:0]  s_axi_arlen = '0;
    logic [2:0]  s_axi_arsize = 3'd3;
    logic [1:0]  s_axi_arburst = 2'b01;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [63:0] s_axi_rdata;
    logic        s_axi_rlast;
    logic [1:0]  s_axi_rresp;
    logic        mem_we = 1'b0;
    logic [63:0] mem_waddr = '0;
    logic [63:0] mem_wdata = '0;

    always #5 clk = ~clk;

    axi_read_responder #(.MEM_WORDS(MEM_WORDS), .RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .reset(reset),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rlast(s_axi_rlast), .s_axi_rresp(s_axi_rresp),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [1:0]  exp_resp;
        int          exp_beats;
    } vec_t;

    beat_t       sb_q[$];
    beat_t       mon_e;
    logic [63:0] mdl_mem [MEM_WORDS];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          cyc = 0;
    int          beats_seen = 0;
    int          hs_cyc = 0;
    int          first_rv_cyc = -1;
    bit          first_pending = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Beat monitor: every handshake seen before the clock edge is popped and compared.
    always @(negedge clk) begin
        if (first_pending && s_axi_rvalid) begin
            first_rv_cyc  = cyc;
            first_pending = 1'b0;
        end
        if (s_axi_rvalid && s_axi_rready) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_beat: got rdata %0h with no beat outstanding", s_axi_rdata);
            end else begin
                mon_e = sb_q.pop_front();
                chk("rdata", s_axi_rdata, mon_e.data);
                chk("rresp", 64'(s_axi_rresp), 64'(mon_e.resp));
                chk("rlast", 64'(s_axi_rlast), 64'(mon_e.last));
                beats_seen++;
            end
        end
    end

    function automatic logic [63:0] model_addr(input logic [63:0] start, input logic [7:0] len,
                                               input logic [1:0] burst, input int i);
        logic [63:0] sz, base;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
            sz   = (64'(len) + 64'd1) * 64'd8;
            base = start - (start % sz);
            return base + ((start - base + 64'(i) * 64'd8) % sz);
        end
        return start + 64'(i) * 64'd8;
    endfunction

    task automatic issue(input vec_t v);
        beat_t       e;
        logic [63:0] a;
        bit          ok;
        for (int i = 0; i <= int'(v.len); i++) begin
            a      = model_addr(v.addr, v.len, v.burst, i);
            e.data = (a >= MEM_BYTES) ? 64'd0 : mdl_mem[a[12:3]];
            e.resp = (a >= MEM_BYTES) ? 2'b11 : v.exp_resp;
            e.last = (i == int'(v.len));
            sb_q.push_back(e);
        end
        beats_seen    = 0;
        first_rv_cyc  = -1;
        first_pending = 1'b1;
        @(posedge clk); #2;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = v.addr;
        s_axi_arlen   = v.len;
        s_axi_arsize  = v.size;
        s_axi_arburst = v.burst;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_axi_arready) begin
                hs_cyc = cyc;
                ok     = 1'b1;
                break;
            end
        end
        @(posedge clk); #2;
        s_axi_arvalid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL ar_handshake: got no arready within 20 cycles, expected arready=1");
            sb_q.delete();
        end
    endtask

    task automatic wait_done(input int maxc);
        for (int k = 0; k < maxc; k++) begin
            @(negedge clk); #1;
            if (sb_q.size() == 0) break;
        end
        if (sb_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL burst_timeout: got %0d beats outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
        chk("idle_arready", 64'(s_axi_arready), 64'd1);
        chk("idle_rvalid", 64'(s_axi_rvalid), 64'd0);
    endtask

    initial begin
        vec_t tab[10];
        vec_t v;
        logic [63:0] d;

        tab[0] = '{64'h80,   8'd7,  3'd3, 2'b01, 2'b00, 8};
        tab[1] = '{64'h98,   8'd3,  3'd3, 2'b10, 2'b00, 4};
        tab[2] = '{64'h1FF8, 8'd1,  3'd3, 2'b01, 2'b00, 2};
        tab[3] = '{64'h100,  8'd2,  3'd2, 2'b01, 2'b10, 3};
        tab[4] = '{64'h40,   8'd0,  3'd3, 2'b01, 2'b00, 1};
        tab[5] = '{64'h200,  8'd3,  3'd3, 2'b00, 2'b00, 4};
        tab[6] = '{64'h88,   8'd2,  3'd3, 2'b10, 2'b10, 3};
        tab[7] = '{64'h300,  8'd1,  3'd3, 2'b11, 2'b10, 2};
        tab[8] = '{64'h3E8,  8'd7,  3'd3, 2'b10, 2'b00, 8};
        tab[9] = '{64'h1070, 8'd15, 3'd3, 2'b10, 2'b00, 16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", 64'(s_axi_arready), 64'd1);
        chk("rst_rvalid",  64'(s_axi_rvalid),  64'd0);
        chk("rst_rlast",   64'(s_axi_rlast),   64'd0);
        chk("rst_rresp",   64'(s_axi_rresp),   64'd0);
        chk("rst_rdata",   s_axi_rdata,        64'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        // Preload every word; low address bits are deliberately non-zero.
        for (int w = 0; w < int'(MEM_WORDS); w++) begin
            if (w >= 16 && w < 24) d = 64'hA0 + 64'(w - 16);
            else                   d = {16'hBEEF, 16'(w), 32'(w * 32'h9E37_79B1)};
            mdl_mem[w] = d;
            mem_we    = 1'b1;
            mem_waddr = 64'(w) * 64'd8 + 64'(w % 8);
            mem_wdata = d;
            @(posedge clk); #2;
        end
        mem_we = 1'b0;

        for (int t = 0; t < 10; t++) begin
            issue(tab[t]);
            wait_done(200);
            chk($sformatf("beats_%0d", t), 64'(beats_seen), 64'(tab[t].exp_beats));
            chk($sformatf("first_latency_%0d", t), 64'(first_rv_cyc - hs_cyc), 64'(RD_LATENCY + 1));
        end

        // rready low for 5 cycles while beat 3 is presented.
        v = tab[0];
        issue(v);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (beats_seen >= 3) break;
        end
        @(posedge clk); #2;
        s_axi_rready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_rvalid", 64'(s_axi_rvalid), 64'd1);
            chk("stall_rdata",  s_axi_rdata,       mdl_mem[19]);
            chk("stall_rlast",  64'(s_axi_rlast),  64'd0);
            chk("stall_rresp",  64'(s_axi_rresp),  64'd0);
        end
        @(posedge clk); #2;
        s_axi_rready = 1'b1;
        wait_done(100);
        chk("stall_beats", 64'(beats_seen), 64'd8);

        // Reset while beat 2 of 8 is on the bus.
        issue(v);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (beats_seen >= 2) break;
        end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        sb_q.delete();
        first_pending = 1'b0;
        chk("midrst_rvalid",  64'(s_axi_rvalid),  64'd0);
        chk("midrst_arready", 64'(s_axi_arready), 64'd1);
        chk("midrst_rlast",   64'(s_axi_rlast),   64'd0);
        chk("midrst_rresp",   64'(s_axi_rresp),   64'd0);
        chk("midrst_rdata",   s_axi_rdata,        64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("inrst_rvalid", 64'(s_axi_rvalid), 64'd0);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("postrst_arready", 64'(s_axi_arready), 64'd1);
        issue(tab[1]);
        wait_done(100);
        chk("postrst_beats", 64'(beats_seen), 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
